// File: rtl/rv32i_types.sv
// Shared types and widths for the data-memory arbiter.
package rv32i_types;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MASK_W    = 4;
  localparam int unsigned ROB_TAG_W = 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE_WAIT = 2'd1,
    LOAD_WAIT  = 2'd2
  } dmem_arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates committed stores and speculative loads onto a single data-memory
// port, one transaction in flight at a time, with bounded store starvation.
module dmem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sb_req_valid,
  output logic                 sb_req_ready,
  input  logic [XLEN-1:0]      sb_addr,
  input  logic [XLEN-1:0]      sb_wdata,
  input  logic [MASK_W-1:0]    sb_wmask,
  input  logic                 sb_full,
  input  logic                 ld_req_valid,
  output logic                 ld_req_ready,
  input  logic [XLEN-1:0]      ld_addr,
  input  logic [MASK_W-1:0]    ld_rmask,
  input  logic [ROB_TAG_W-1:0] ld_rob_tag,
  output logic                 ld_resp_valid,
  output logic [XLEN-1:0]      ld_rdata,
  output logic [ROB_TAG_W-1:0] ld_resp_rob_tag,
  input  logic                 branch_mispredicted,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [MASK_W-1:0]    dmem_rmask,
  output logic [MASK_W-1:0]    dmem_wmask,
  output logic [XLEN-1:0]      dmem_wdata,
  input  logic [XLEN-1:0]      dmem_rdata,
  input  logic                 dmem_resp
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  dmem_arb_state_t        state_q;
  logic [CNT_W-1:0]       starve_cnt_q;
  logic                   squash_q;
  logic [ROB_TAG_W-1:0]   tag_q;
  logic                   starve_at_limit;
  logic                   grant_st;
  logic                   grant_ld;

  assign starve_at_limit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // Grant selection in IDLE: full buffer or starved store first, then loads
  // (unless flushing), then any remaining store.
  always_comb begin
    grant_st = 1'b0;
    grant_ld = 1'b0;
    if (state_q == IDLE) begin
      if (sb_req_valid && (sb_full || starve_at_limit)) begin
        grant_st = 1'b1;
      end else if (ld_req_valid && !branch_mispredicted) begin
        grant_ld = 1'b1;
      end else if (sb_req_valid) begin
        grant_st = 1'b1;
      end
    end
  end

  // Ready doubles as the grant, so an accept is valid & grant.
  assign sb_req_ready = grant_st;
  assign ld_req_ready = grant_ld;

  // FSM, starvation counter, squash tracking and registered memory/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      starve_cnt_q    <= '0;
      squash_q        <= 1'b0;
      tag_q           <= '0;
      ld_resp_valid   <= 1'b0;
      ld_rdata        <= '0;
      ld_resp_rob_tag <= '0;
      dmem_addr       <= '0;
      dmem_rmask      <= '0;
      dmem_wmask      <= '0;
      dmem_wdata      <= '0;
    end else begin
      ld_resp_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_st) begin
            state_q      <= STORE_WAIT;
            dmem_addr    <= sb_addr;
            dmem_wdata   <= sb_wdata;
            dmem_wmask   <= sb_wmask;
            dmem_rmask   <= '0;
            starve_cnt_q <= '0;
          end else if (grant_ld) begin
            state_q    <= LOAD_WAIT;
            dmem_addr  <= ld_addr;
            dmem_rmask <= ld_rmask;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
            tag_q      <= ld_rob_tag;
            if (sb_req_valid && !starve_at_limit) begin
              starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end
          end
        end
        STORE_WAIT: begin
          if (dmem_resp) begin
            state_q    <= IDLE;
            dmem_addr  <= '0;
            dmem_rmask <= '0;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
          end
        end
        LOAD_WAIT: begin
          if (branch_mispredicted) begin
            squash_q <= 1'b1;
          end
          if (dmem_resp) begin
            state_q         <= IDLE;
            squash_q        <= 1'b0;
            ld_resp_valid   <= !(squash_q || branch_mispredicted);
            ld_rdata        <= dmem_rdata;
            ld_resp_rob_tag <= tag_q;
            dmem_addr       <= '0;
            dmem_rmask      <= '0;
            dmem_wmask      <= '0;
            dmem_wdata      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive load grants while a store is pending.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have sb_req_valid/sb_req_ready (in/out, 1), the committed-store request handshake.
REQ-005 SHALL have sb_addr (in, 32), sb_wdata (in, 32) and sb_wmask (in, 4), the store payload.
REQ-006 SHALL have sb_full, input, 1, meaning the store buffer is at capacity.
REQ-007 SHALL have ld_req_valid/ld_req_ready (in/out, 1), the load request handshake.
REQ-008 SHALL have ld_addr (in, 32), ld_rmask (in, 4) and ld_rob_tag (in, 5), the load payload.
REQ-009 SHALL have ld_resp_valid (out, 1), ld_rdata (out, 32) and ld_resp_rob_tag (out, 5), the load result.
REQ-010 SHALL have branch_mispredicted, input, 1, the pipeline flush.
REQ-011 SHALL have dmem_addr (out, 32), dmem_rmask (out, 4), dmem_wmask (out, 4) and dmem_wdata (out, 32), the single data-memory port.
REQ-012 SHALL have dmem_rdata (in, 32) and dmem_resp (in, 1), the memory response.

Function
REQ-013 SHALL implement FSM states IDLE, STORE_WAIT and LOAD_WAIT, with exactly one memory transaction outstanding at a time.
REQ-014 SHALL assert sb_req_ready and ld_req_ready only in IDLE, and SHALL assert at most one of them in any cycle.
REQ-015 SHALL grant in IDLE by these rules, in order:
- store if sb_full=1 and sb_req_valid=1;
- else store if starve_cnt==STARVE_LIMIT and sb_req_valid=1;
- else load if ld_req_valid=1 and branch_mispredicted=0;
- else store if sb_req_valid=1.
REQ-016 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each load accept while sb_req_valid=1, and SHALL clear it on each store accept.
REQ-017 SHALL register the accepted payload into dmem_* outputs on the accept edge, so dmem_* are valid from the cycle after accept.
REQ-018 SHALL hold dmem_addr/mask/wdata stable through the cycle dmem_resp=1, and SHALL drive them to 0 on the following cycle.
REQ-019 SHALL drive dmem_wmask=0 for loads and dmem_rmask=0 for stores.
REQ-020 SHALL return the FSM to IDLE on the edge after dmem_resp=1 in either WAIT state, allowing a new grant in that IDLE cycle (minimum 3-cycle turnaround with a 1-cycle memory).
REQ-021 SHALL pulse ld_resp_valid for exactly 1 cycle on the cycle after dmem_resp in LOAD_WAIT, carrying the registered dmem_rdata and ld_rob_tag, unless the load is squashed.
REQ-022 SHALL set a squash flag when branch_mispredicted=1 during LOAD_WAIT, including the dmem_resp cycle; a squashed load SHALL complete on memory but SHALL NOT assert ld_resp_valid, and the flag SHALL clear on return to IDLE.
REQ-023 SHALL NOT let branch_mispredicted affect store transactions or starve_cnt, since stores are already committed.
REQ-024 SHALL, when branch_mispredicted=1 in IDLE with only ld_req_valid=1, accept nothing that cycle.
REQ-025 SHALL ignore dmem_resp in IDLE.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set state=IDLE, starve_cnt=0, squash=0, and all outputs (ready, resp, dmem_*) to 0 from the next cycle.
REQ-027 SHALL abandon any in-flight transaction on reset mid-operation, with no ld_resp_valid emitted for it.

Structure
REQ-028 SHALL place the state enum dmem_arb_state_t in package rv32i_types; STARVE_LIMIT SHALL remain a module parameter.
REQ-029 SHALL be implemented as a single module with no sub-module; the FSM, counter and output registers are all local.

Verification
REQ-030 SHALL cover load only: ld_addr=0x1000, rmask=0xF, tag=3, memory responds after 2 cycles with 0xDEADBEEF -> one ld_resp_valid pulse, rdata=0xDEADBEEF, tag=3; dmem_wmask stays 0.
REQ-031 SHALL cover simultaneous requests with sb_full=1: store 0x2000/0x0000_00AA/mask 0x1 plus a load -> store granted first, load granted in the IDLE cycle after the store's dmem_resp.
REQ-032 SHALL cover starvation: sb_req_valid held, loads back-to-back, STARVE_LIMIT=4 -> exactly 4 load grants, then a store grant, then starve_cnt=0.
REQ-033 SHALL cover flush: branch_mispredicted=1 for 1 cycle during LOAD_WAIT -> memory completes, no ld_resp_valid, FSM returns to IDLE.
REQ-034 SHALL cover reset in STORE_WAIT: rst=1 -> next cycle all outputs 0 and state IDLE; a late dmem_resp is ignored.
REQ-035 SHALL cover flush coinciding with a load-only request in IDLE -> ld_req_ready=0 and no dmem activity the next cycle.
